// File: rtl/calc_pkg.sv
// Shared encodings and defaults for the calculator core and its iteration unit.
// CALC_DIV_EN selects whether op=11 is routed to the multi-cycle divider.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  // True when the operation needs the WIDTH-step iterative datapath.
  function automatic logic uses_iter(input logic [1:0] op);
`ifdef CALC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return op == OP_MUL;
`endif
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shared shift-add multiply / restoring divide datapath, one step per cycle for WIDTH cycles.
// The divider step logic is only built when CALC_DIV_EN is defined.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last_step
);

  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [WIDTH:0]   mul_sum;

  assign last_step = running && (cnt == CNT_W'(WIDTH - 1));
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);

`ifdef CALC_DIV_EN
  logic             divide;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // hi holds the partial remainder, lo shifts the dividend out and the quotient in.
  assign shifted = {hi, lo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, operand};
  assign rem_sub = shifted[WIDTH-1:0] - operand;
`else
  logic unused_div_mode;
  assign unused_div_mode = div_mode;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi      <= '0;
      lo      <= '0;
      operand <= '0;
      cnt     <= '0;
      running <= 1'b0;
`ifdef CALC_DIV_EN
      divide  <= 1'b0;
`endif
    end else if (init) begin
      hi      <= '0;
      lo      <= opa;
      operand <= opb;
      cnt     <= '0;
      running <= 1'b1;
`ifdef CALC_DIV_EN
      divide  <= div_mode;
`endif
    end else if (running) begin
      cnt <= last_step ? '0 : cnt + 1'b1;
      if (last_step) running <= 1'b0;
`ifdef CALC_DIV_EN
      if (divide) begin
        hi <= fits ? rem_sub : shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], fits};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
`else
      hi <= mul_sum[WIDTH:1];
      lo <= {mul_sum[0], lo[WIDTH-1:1]};
`endif
    end
  end

endmodule

// File: rtl/calculator_core.sv
// Calculator engine feeding the VGA stage: operand/result registers plus the IDLE/CALC/FIN sequencer.
// Define CALC_DIV_EN to build the restoring divider; otherwise op=11 reports err after one cycle.
module calculator_core
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [1:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state;
  logic [WIDTH-1:0] work_a;
  logic [WIDTH-1:0] work_b;
  logic [1:0]       work_op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic             iter_last;
  logic             iter_init;

  assign iter_init = (state == S_IDLE) && start && uses_iter(op);
  assign add_sum   = {1'b0, work_a} + {1'b0, work_b};

  calc_iter_unit #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .init     (iter_init),
    .div_mode (op == OP_DIV),
    .opa      (A),
    .opb      (B),
    .hi       (iter_hi),
    .lo       (iter_lo),
    .last_step(iter_last)
  );

  // FIN is the single result cycle for every op; add/sub skip CALC entirely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      A       <= '0;
      B       <= '0;
      C       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      work_a  <= '0;
      work_b  <= '0;
      work_op <= OP_ADD;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            work_a  <= A;
            work_b  <= B;
            work_op <= op;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= uses_iter(op) ? S_CALC : S_FIN;
          end else begin
            if (load_a) A <= sw;
            if (load_b) B <= sw;
          end
        end
        S_CALC: begin
          if (iter_last) state <= S_FIN;
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          unique case (work_op)
            OP_ADD: begin
              C   <= add_sum[WIDTH-1:0];
              err <= add_sum[WIDTH];
            end
            OP_SUB: begin
              C   <= work_a - work_b;
              err <= work_a < work_b;
            end
            OP_MUL: begin
              C   <= iter_lo;
              err <= |iter_hi;
            end
            default: begin
`ifdef CALC_DIV_EN
              C   <= iter_lo;
              err <= (work_b == '0);
`else
              err <= 1'b1;
`endif
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculator_core.sv
// Scoreboard bench for calculator_core: driver pushes expected results, monitor checks on done.
// Honours CALC_DIV_EN the same way the design does.
module tb_calculator_core;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         load_a;
  logic         load_b;
  logic [1:0]   op;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         busy;
  logic         done;
  logic         err;

  typedef struct {
    int           start_cyc;
    int           lat;
    logic [W-1:0] c;
    logic         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_c = '0;

  calculator_core dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .load_a(load_a),
    .load_b(load_b),
    .op    (op),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic void model_op(input logic [1:0] o, input longint a, input longint b,
                                   input longint c_prev, output longint c, output bit e,
                                   output int lat);
    longint r;
    case (o)
      2'b00: begin r = a + b; c = r % 65536; e = (r > 65535); lat = 1; end
      2'b01: begin c = (a - b + 65536) % 65536; e = (a < b); lat = 1; end
      2'b10: begin r = a * b; c = r % 65536; e = (r > 65535); lat = W + 1; end
      default: begin
`ifdef CALC_DIV_EN
        if (b == 0) begin c = 65535; e = 1'b1; end
        else begin c = a / b; e = 1'b0; end
        lat = W + 1;
`else
        c = c_prev; e = 1'b1; lat = 1;
`endif
      end
    endcase
  endfunction

  // One stimulus cycle; the design is idle exactly when no result is outstanding.
  task automatic applyStimulus(input logic la, input logic lb, input logic st,
                               input logic [1:0] o, input logic [W-1:0] s);
    exp_t   e;
    longint r;
    bit     eb;
    int     lat;
    @(negedge clk);
    sw = s; load_a = la; load_b = lb; start = st; op = o;
    if (sb.size() == 0) begin
      if (st) begin
        model_op(o, longint'(m_a), longint'(m_b), longint'(m_c), r, eb, lat);
        e.start_cyc = cyc + 1;
        e.lat       = lat;
        e.c         = W'(r);
        e.e         = eb;
        e.a         = m_a;
        e.b         = m_b;
        sb.push_back(e);
        m_c = W'(r);
      end else begin
        if (la) m_a = s;
        if (lb) m_b = s;
      end
    end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("wait_idle_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    applyStimulus(1'b1, 1'b0, 1'b0, o, a);
    applyStimulus(1'b0, 1'b1, 1'b0, o, b);
    applyStimulus(1'b0, 1'b0, 1'b1, o, $urandom);
    waitIdle();
  endtask

  // Monitor: compares against the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      if (sb.size() > 0) begin
        mon_e = sb[0];
        if (cyc == mon_e.start_cyc + mon_e.lat) begin
          checkOutput("done", 32'(done), 32'd1);
          checkOutput("C", 32'(C), 32'(mon_e.c));
          checkOutput("err", 32'(err), 32'(mon_e.e));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          checkOutput("A_hold", 32'(A), 32'(mon_e.a));
          checkOutput("B_hold", 32'(B), 32'(mon_e.b));
          void'(sb.pop_front());
        end else begin
          checkOutput("busy_inflight", 32'(busy), 32'd1);
          checkOutput("done_early", 32'(done), 32'd0);
        end
      end else begin
        checkOutput("done_spurious", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; sw = '0; load_a = 1'b0; load_b = 1'b0; op = 2'b00; start = 1'b0;

    // Reset with random inputs toggling.
    repeat (2) begin
      @(negedge clk);
      sw = W'($urandom); load_a = 1'($urandom); load_b = 1'($urandom);
      start = 1'($urandom); op = 2'($urandom);
    end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; start = 1'b0;
    checkOutput("rst_A", 32'(A), 32'd0);
    checkOutput("rst_B", 32'(B), 32'd0);
    checkOutput("rst_C", 32'(C), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    $display("[TB] directed operations");
    runOp(16'h00FF, 16'h0101, 2'b00);
    checkOutput("add_C", 32'(C), 32'h0200);
    runOp(16'hFFFF, 16'h0001, 2'b00);
    checkOutput("add_wrap_err", 32'(err), 32'd1);
    runOp(16'h0005, 16'h0007, 2'b01);
    checkOutput("sub_C", 32'(C), 32'hFFFE);
    runOp(16'h0123, 16'h0045, 2'b10);
    checkOutput("mul_C", 32'(C), 32'h4E6F);
    runOp(16'h0100, 16'h0100, 2'b10);
    checkOutput("mul_ovf_err", 32'(err), 32'd1);
    runOp(16'h1234, 16'h0010, 2'b11);
    runOp(16'h1234, 16'h0000, 2'b11);
    checkOutput("div0_err", 32'(err), 32'd1);

    // Both loads in one cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 16'h4321);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 16'h0000);
    waitIdle();

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 1) == 0) ra = W'($urandom_range(0, 1023));
      runOp(ra, rb, 2'($urandom_range(0, 3)));
    end

    $display("[TB] interference");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h0011);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 16'h0022);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 16'h5555);
    waitIdle();
    checkOutput("interf_A", 32'(A), 32'h0011);
    checkOutput("interf_C", 32'(C), 32'h0242);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 16'h7777);
    waitIdle();
    checkOutput("load_with_start_A", 32'(A), 32'h0011);
    checkOutput("load_with_start_C", 32'(C), 32'h0033);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_a = '0; m_b = '0; m_c = '0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_A", 32'(A), 32'd0);
    checkOutput("midrst_B", 32'(B), 32'd0);
    checkOutput("midrst_C", 32'(C), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calculator_core.md
Name: calculator_core

Overview:
- Arithmetic engine directly upstream of the VGA output stage.
- Captures two 16-bit operands from board switches on load strobes, then computes the result C on a start strobe.
- Drives A, B and C as stable registers, which the display stage renders as binary digit rows.
- Multi-cycle shift-add multiply and restoring divide; single-cycle add/subtract.

Parameters:
- WIDTH, 16, operand/result width; must match the display stage's 16-bit A/B/C.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- sw  in  WIDTH  operand value from switches
- load_a  in  1  single-cycle strobe (debounced upstream): A <= sw
- load_b  in  1  single-cycle strobe: B <= sw
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- start  in  1  single-cycle strobe: begin operation
- A  out  WIDTH  operand A register, to display
- B  out  WIDTH  operand B register, to display
- C  out  WIDTH  result register, to display
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when C updates
- err  out  1  sticky status of the last operation: overflow, borrow or divide-by-zero

Behaviour:
Reset:
- rst low at a clk edge sets A, B, C, busy, done, err and the counter to 0; state becomes IDLE.
- Reset mid-operation aborts; no done pulse is produced.

FSM states:
- IDLE → (start) CALC → FIN → IDLE.
- In IDLE, start captures A, B and op into internal working registers, clears err, and sets busy at the same edge.
- Loads are accepted only in IDLE.
- load_a/load_b arriving in the same cycle as start, or while busy, are dropped.
- start while busy is ignored.
- load_a and load_b together in IDLE: both load sw.

Latency (start sampled at edge k):
- C updates and done=1 after edge k+N; busy falls at that same edge.
- add/sub: N=1.
- mul/div: N=WIDTH+1 (WIDTH iterations plus one result cycle).
- done lasts exactly one cycle.
- A and B never change during CALC.

Operations:
- add: C = (A+B) mod 2^WIDTH; err = carry out.
- sub: C = (A−B) mod 2^WIDTH; err = (A<B).
- mul: shift-add over 2·WIDTH-bit product; C = low WIDTH bits; err = (high half != 0).
- div: restoring, unsigned; C = quotient, remainder discarded; B==0 → C = all ones, err=1, same latency.
- Iteration counter counts 0..WIDTH−1 in CALC; wrap-around is not permitted.

Optional Feature:
- Macro CALC_DIV_EN.
- Defined: op=11 performs restoring division as above.
- Undefined: divider datapath is not built; op=11 completes with N=1, C unchanged, err=1.

Decomposition:
- Package calc_pkg holds:
  - op encoding constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state encoding S_IDLE, S_CALC, S_FIN
  - WIDTH default
- One natural sub-module, calc_iter_unit, containing the shared multi-cycle datapath:
  - shift-add multiply / restoring divide step registers
  - iteration counter and completion flag
- The FSM and operand/result registers stay in calculator_core.

Test Plan:
- Reset: hold rst=0 two cycles with random inputs → A=B=C=0, busy=done=err=0.
- Add: load_a sw=0x00FF, load_b sw=0x0101, start op=00 → one cycle later C=0x0200, done pulse, err=0. Repeat with 0xFFFF+0x0001 → C=0x0000, err=1.
- Subtract: A=0x0005, B=0x0007, op=01 → C=0xFFFE, err=1.
- Multiply: A=0x0123, B=0x0045, op=10 → C=0x4E6F, err=0, done exactly WIDTH+1 cycles after start, busy high throughout. Then A=0x0100, B=0x0100 → C=0x0000, err=1.
- Divide (CALC_DIV_EN): A=0x1234, B=0x0010 → C=0x0123. B=0 → C=0xFFFF, err=1. Without the macro: op=11 → err=1 after one cycle, C unchanged.
- Interference: load_a pulsed mid-multiply and start re-pulsed while busy → A and the result unaffected. Then assert rst mid-divide → all outputs 0, no done.
